// File: rtl/csi_rx_pkg.sv
// Shared types and defaults for the CSI-2 receive byte-clock frequency monitor.
// The state encoding is visible on the lock_state debug port.
package csi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  localparam int DEF_REF_WIN       = 1024;
  localparam int DEF_PRESCALE_LOG2 = 3;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_CNT_MIN       = 56;
  localparam int DEF_CNT_MAX       = 72;
  localparam int DEF_GOOD_WINDOWS  = 4;
  localparam int DEF_BAD_WINDOWS   = 2;

  // Run counters only ever need to reach the larger of the two window targets.
  function automatic int run_width(input int good_windows, input int bad_windows);
    int largest;
    largest = (good_windows > bad_windows) ? good_windows : bad_windows;
    return $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/csi_rx_toggle_sync.sv
// Divides byte_clock down, carries the divided MSB into ref_clock and turns each
// rising edge of it into a single-cycle edge_pulse.
module csi_rx_toggle_sync
  import csi_rx_pkg::*;
#(
  parameter int PRESCALE_LOG2 = DEF_PRESCALE_LOG2
) (
  input  logic byte_clock,
  input  logic ref_clock,
  input  logic reset_in_demet,
  output logic edge_pulse
);

  logic [PRESCALE_LOG2-1:0] prescale;
  logic                     sync_1;
  logic                     sync_2;
  logic                     sync_hist;

  // The prescaler has no reset: byte_clock may be absent while reset is applied.
  always_ff @(posedge byte_clock) begin
    prescale <= prescale + PRESCALE_LOG2'(1);
  end

  always_ff @(posedge ref_clock or posedge reset_in_demet) begin
    if (reset_in_demet) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_hist <= 1'b0;
    end else begin
      sync_1    <= prescale[PRESCALE_LOG2-1];
      sync_2    <= sync_1;
      sync_hist <= sync_2;
    end
  end

  assign edge_pulse = sync_2 & ~sync_hist;

endmodule

// File: rtl/csi_rx_clk_freq_mon.sv
// Measures byte_clock against fixed ref_clock windows and only reports clk_ok
// after a run of in-range windows; clk_ok gates the downstream detector enable.
module csi_rx_clk_freq_mon
  import csi_rx_pkg::*;
#(
  parameter int REF_WIN       = DEF_REF_WIN,
  parameter int PRESCALE_LOG2 = DEF_PRESCALE_LOG2,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int CNT_MIN       = DEF_CNT_MIN,
  parameter int CNT_MAX       = DEF_CNT_MAX,
  parameter int GOOD_WINDOWS  = DEF_GOOD_WINDOWS,
  parameter int BAD_WINDOWS   = DEF_BAD_WINDOWS
) (
  input  logic             ref_clock,
  input  logic             reset_in_demet,
  input  logic             byte_clock,
  input  logic             enable_in,
  output logic             clk_ok,
  output logic             enable_out,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic [1:0]       lock_state
);

  localparam int WIN_W = $clog2(REF_WIN);
  localparam int RUN_W = run_width(GOOD_WINDOWS, BAD_WINDOWS);

  lock_state_t      state;
  lock_state_t      next_state;
  logic             edge_pulse;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] win_total;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] bad_run;
  logic             win_end;
  logic             in_range;
  logic             good_hit;
  logic             bad_hit;

  csi_rx_toggle_sync #(
    .PRESCALE_LOG2 (PRESCALE_LOG2)
  ) u_toggle_sync (
    .byte_clock     (byte_clock),
    .ref_clock      (ref_clock),
    .reset_in_demet (reset_in_demet),
    .edge_pulse     (edge_pulse)
  );

  // An edge arriving on the closing cycle belongs to the closing window.
  assign win_end   = (state != IDLE) && (win_cnt == WIN_W'(REF_WIN - 1));
  assign win_total = (edge_pulse && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign in_range  = (win_total >= CNT_W'(CNT_MIN)) && (win_total <= CNT_W'(CNT_MAX));
  assign good_hit  = in_range && (good_run == RUN_W'(GOOD_WINDOWS - 1));
  assign bad_hit   = !in_range && (bad_run == RUN_W'(BAD_WINDOWS - 1));

  always_ff @(posedge ref_clock or posedge reset_in_demet) begin
    if (reset_in_demet) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!enable_in) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = ACQUIRE;
        ACQUIRE: if (win_end && good_hit) next_state = LOCKED;
        LOCKED:  if (win_end && bad_hit) next_state = ACQUIRE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    clk_ok     = (state == LOCKED);
    lock_state = state;
  end

  // Dropping enable_in wins over a coincident window end: nothing is reported.
  always_ff @(posedge ref_clock or posedge reset_in_demet) begin
    if (reset_in_demet) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      good_run   <= '0;
      bad_run    <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      enable_out <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      enable_out <= enable_in & clk_ok;
      if ((state == IDLE) || !enable_in) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        good_run <= '0;
        bad_run  <= '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        if (win_end) begin
          edge_cnt   <= '0;
          meas_count <= win_total;
          meas_valid <= 1'b1;
          case (state)
            ACQUIRE: begin
              bad_run <= '0;
              if (in_range && !good_hit) begin
                good_run <= good_run + RUN_W'(1);
              end else begin
                good_run <= '0;
              end
            end
            LOCKED: begin
              good_run <= '0;
              if (!in_range && !bad_hit) begin
                bad_run <= bad_run + RUN_W'(1);
              end else begin
                bad_run <= '0;
              end
            end
            default: begin
              good_run <= '0;
              bad_run  <= '0;
            end
          endcase
        end else begin
          edge_cnt <= win_total;
        end
      end
    end
  end

endmodule

// File: tb/tb_csi_rx_clk_freq_mon.sv
// Scoreboard bench: each scenario queues the expected window results it provokes
// and compares them as meas_valid pulses arrive.
module tb_csi_rx_clk_freq_mon;
  import csi_rx_pkg::*;

  typedef struct {
    int lo;
    int hi;
    bit ok;
  } win_exp_t;

  logic        ref_clock;
  logic        reset_in_demet;
  logic        byte_clock;
  logic        enable_in;
  logic        clk_ok;
  logic        enable_out;
  logic [15:0] meas_count;
  logic        meas_valid;
  logic [1:0]  lock_state;

  win_exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int byte_half = 50;
  bit byte_run  = 1'b1;

  csi_rx_clk_freq_mon dut (
    .ref_clock      (ref_clock),
    .reset_in_demet (reset_in_demet),
    .byte_clock     (byte_clock),
    .enable_in      (enable_in),
    .clk_ok         (clk_ok),
    .enable_out     (enable_out),
    .meas_count     (meas_count),
    .meas_valid     (meas_valid),
    .lock_state     (lock_state)
  );

  // ref_clock period 50 units; byte edges sit on a 3+10k grid, never on a ref edge.
  initial begin
    ref_clock = 1'b0;
    forever #25 ref_clock = ~ref_clock;
  end

  initial begin
    byte_clock = 1'b0;
    #3;
    forever begin
      #(byte_half);
      if (byte_run) byte_clock = ~byte_clock;
    end
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge ref_clock);
      if (meas_valid === 1'b1) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_in_demet = 1'b1;
    enable_in      = 1'b1;
    repeat (4) @(negedge ref_clock);
    n_checks++;
    if (clk_ok !== 1'b0) $display("[TB] FAIL reset_clk_ok: got %b, expected 0", clk_ok);
    else n_pass++;
    n_checks++;
    if (enable_out !== 1'b0) $display("[TB] FAIL reset_enable_out: got %b, expected 0", enable_out);
    else n_pass++;
    n_checks++;
    if (meas_count !== 16'd0) $display("[TB] FAIL reset_meas_count: got %0d, expected 0", meas_count);
    else n_pass++;
    n_checks++;
    if (meas_valid !== 1'b0) $display("[TB] FAIL reset_meas_valid: got %b, expected 0", meas_valid);
    else n_pass++;
    n_checks++;
    if (lock_state !== IDLE) $display("[TB] FAIL reset_state: got %0d, expected 0", lock_state);
    else n_pass++;
    reset_in_demet = 1'b0;
  endtask

  task automatic test_lock();
    win_exp_t e;
    bit got;
    exp_q.push_back('{62, 66, 1'b0});
    exp_q.push_back('{64, 64, 1'b0});
    exp_q.push_back('{64, 64, 1'b0});
    exp_q.push_back('{64, 64, 1'b1});
    for (int i = 0; i < 4; i++) begin
      wait_valid(got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) $display("[TB] FAIL lock_w%0d: no meas_valid, expected count %0d..%0d", i, e.lo, e.hi);
      else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok)
        $display("[TB] FAIL lock_w%0d: count=%0d clk_ok=%b, expected %0d..%0d clk_ok=%b", i, meas_count, clk_ok, e.lo, e.hi, e.ok);
      else n_pass++;
    end
    n_checks++;
    if (enable_out !== 1'b0) $display("[TB] FAIL lock_enable_early: got %b, expected 0", enable_out);
    else n_pass++;
    @(negedge ref_clock);
    n_checks++;
    if (enable_out !== 1'b1 || meas_valid !== 1'b0)
      $display("[TB] FAIL lock_enable_follow: enable_out=%b meas_valid=%b, expected 1 and 0", enable_out, meas_valid);
    else n_pass++;
    exp_q.push_back('{64, 64, 1'b1});
    wait_valid(got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) $display("[TB] FAIL lock_hold: no meas_valid, expected count %0d", e.lo);
    else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok)
      $display("[TB] FAIL lock_hold: count=%0d clk_ok=%b, expected %0d clk_ok=%b", meas_count, clk_ok, e.lo, e.ok);
    else n_pass++;
  endtask

  task automatic test_stopped();
    win_exp_t e;
    bit got;
    byte_run = 1'b0;
    exp_q.push_back('{0, 2, 1'b1});
    exp_q.push_back('{0, 0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      wait_valid(got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) $display("[TB] FAIL stop_w%0d: no meas_valid, expected count %0d..%0d", i, e.lo, e.hi);
      else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok)
        $display("[TB] FAIL stop_w%0d: count=%0d clk_ok=%b, expected %0d..%0d clk_ok=%b", i, meas_count, clk_ok, e.lo, e.hi, e.ok);
      else n_pass++;
    end
    n_checks++;
    if (enable_out !== 1'b1) $display("[TB] FAIL stop_enable_lag: got %b, expected 1", enable_out);
    else n_pass++;
    @(negedge ref_clock);
    n_checks++;
    if (enable_out !== 1'b0 || lock_state !== ACQUIRE)
      $display("[TB] FAIL stop_drop: enable_out=%b state=%0d, expected 0 and 1", enable_out, lock_state);
    else n_pass++;
  endtask

  task automatic test_off_frequency();
    win_exp_t e;
    bit got;
    byte_half = 40;
    byte_run  = 1'b1;
    exp_q.push_back('{76, 81, 1'b0});
    for (int i = 0; i < 3; i++) exp_q.push_back('{80, 80, 1'b0});
    for (int i = 0; i < 4; i++) begin
      wait_valid(got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) $display("[TB] FAIL fast_w%0d: no meas_valid, expected count %0d..%0d", i, e.lo, e.hi);
      else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok)
        $display("[TB] FAIL fast_w%0d: count=%0d clk_ok=%b, expected %0d..%0d clk_ok=%b", i, meas_count, clk_ok, e.lo, e.hi, e.ok);
      else n_pass++;
    end
    n_checks++;
    if (dut.good_run !== 3'd0 || lock_state !== ACQUIRE)
      $display("[TB] FAIL fast_no_lock: good_run=%0d state=%0d, expected 0 and 1", dut.good_run, lock_state);
    else n_pass++;
  endtask

  task automatic test_glitch_window();
    win_exp_t e;
    bit got;
    byte_half = 50;
    exp_q.push_back('{62, 66, 1'b0});
    exp_q.push_back('{64, 64, 1'b0});
    exp_q.push_back('{64, 64, 1'b0});
    exp_q.push_back('{64, 64, 1'b1});
    for (int i = 0; i < 4; i++) begin
      wait_valid(got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) $display("[TB] FAIL relock_w%0d: no meas_valid, expected count %0d..%0d", i, e.lo, e.hi);
      else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok)
        $display("[TB] FAIL relock_w%0d: count=%0d clk_ok=%b, expected %0d..%0d clk_ok=%b", i, meas_count, clk_ok, e.lo, e.hi, e.ok);
      else n_pass++;
    end
    byte_half = 80;
    exp_q.push_back('{38, 42, 1'b1});
    wait_valid(got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) $display("[TB] FAIL glitch_slow: no meas_valid, expected count %0d..%0d", e.lo, e.hi);
    else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok || dut.bad_run !== 3'd1)
      $display("[TB] FAIL glitch_slow: count=%0d clk_ok=%b bad_run=%0d, expected %0d..%0d 1 1", meas_count, clk_ok, dut.bad_run, e.lo, e.hi);
    else n_pass++;
    byte_half = 50;
    exp_q.push_back('{62, 66, 1'b1});
    wait_valid(got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) $display("[TB] FAIL glitch_recover: no meas_valid, expected count %0d..%0d", e.lo, e.hi);
    else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok || dut.bad_run !== 3'd0)
      $display("[TB] FAIL glitch_recover: count=%0d clk_ok=%b bad_run=%0d, expected %0d..%0d 1 0", meas_count, clk_ok, dut.bad_run, e.lo, e.hi);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    win_exp_t e;
    bit got;
    int pulses;
    exp_q.push_back('{64, 64, 1'b1});
    wait_valid(got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || meas_count !== 16'(e.lo) || clk_ok !== e.ok)
      $display("[TB] FAIL drop_pre: valid=%b count=%0d clk_ok=%b, expected 1 %0d 1", got, meas_count, clk_ok, e.lo);
    else n_pass++;
    repeat (300) @(negedge ref_clock);
    enable_in = 1'b0;
    @(negedge ref_clock);
    n_checks++;
    if (lock_state !== IDLE || clk_ok !== 1'b0 || enable_out !== 1'b0)
      $display("[TB] FAIL drop_idle: state=%0d clk_ok=%b enable_out=%b, expected 0 0 0", lock_state, clk_ok, enable_out);
    else n_pass++;
    pulses = 0;
    repeat (1500) begin
      @(negedge ref_clock);
      if (meas_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || meas_count !== 16'd64)
      $display("[TB] FAIL drop_hold: pulses=%0d count=%0d, expected 0 and 64", pulses, meas_count);
    else n_pass++;
    enable_in = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{64, 64, 1'b0});
    exp_q.push_back('{64, 64, 1'b1});
    for (int i = 0; i < 4; i++) begin
      wait_valid(got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) $display("[TB] FAIL reen_w%0d: no meas_valid, expected count %0d..%0d", i, e.lo, e.hi);
      else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok)
        $display("[TB] FAIL reen_w%0d: count=%0d clk_ok=%b, expected %0d..%0d clk_ok=%b", i, meas_count, clk_ok, e.lo, e.hi, e.ok);
      else n_pass++;
    end
  endtask

  task automatic test_reset_locked();
    win_exp_t e;
    bit got;
    repeat (200) @(negedge ref_clock);
    #10;
    reset_in_demet = 1'b1;
    #1;
    n_checks++;
    if (clk_ok !== 1'b0 || enable_out !== 1'b0 || meas_valid !== 1'b0)
      $display("[TB] FAIL areset_flags: clk_ok=%b enable_out=%b meas_valid=%b, expected 0 0 0", clk_ok, enable_out, meas_valid);
    else n_pass++;
    n_checks++;
    if (meas_count !== 16'd0 || lock_state !== IDLE)
      $display("[TB] FAIL areset_state: count=%0d state=%0d, expected 0 and 0", meas_count, lock_state);
    else n_pass++;
    repeat (3) @(negedge ref_clock);
    reset_in_demet = 1'b0;
    exp_q.push_back('{62, 66, 1'b0});
    exp_q.push_back('{64, 64, 1'b0});
    exp_q.push_back('{64, 64, 1'b0});
    exp_q.push_back('{64, 64, 1'b1});
    for (int i = 0; i < 4; i++) begin
      wait_valid(got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got) $display("[TB] FAIL rst_w%0d: no meas_valid, expected count %0d..%0d", i, e.lo, e.hi);
      else if (int'(meas_count) < e.lo || int'(meas_count) > e.hi || clk_ok !== e.ok)
        $display("[TB] FAIL rst_w%0d: count=%0d clk_ok=%b, expected %0d..%0d clk_ok=%b", i, meas_count, clk_ok, e.lo, e.hi, e.ok);
      else n_pass++;
    end
  endtask

  initial begin
    reset_in_demet = 1'b1;
    enable_in      = 1'b1;
    test_reset();
    test_lock();
    test_stopped();
    test_off_frequency();
    test_glitch_window();
    test_enable_drop();
    test_reset_locked();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
